// File: rtl/ccr_branch_unit.sv
// ---------------------------------------------------------------------------
// ccr_branch_unit
//
// EX-stage condition-code and branch-resolution block sitting right after the
// 8-bit ALU. Keeps the condition-code register CCR = {V,C,N,Z}, updates it from
// every executed instruction, resolves JZ/JN/JC/JV/LOOP against the registered
// flags and presents a registered one-cycle branch request plus target to fetch.
//
// Optional feature (compile-time macro CCR_SAVE_EN):
//   defined   : int_save snapshots CCR into a shadow register, RTI restores it.
//   undefined : no shadow register, int_save is ignored, RTI leaves CCR alone.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous reset, active-high, overrides everything
//   ex_valid   in   1    instruction in EX is valid
//   stall      in   1    hold all state; br_taken drops next cycle
//   flush      in   1    kill the EX instruction (no flag update, no branch)
//   alu_op     in   OPW  operation code of the EX instruction
//   a          in   W    ALU operand A (LOOP counter value)
//   b          in   W    ALU operand B (jump target for branch ops)
//   result     in   W    ALU result of the EX instruction
//   int_save   in   1    interrupt entry, snapshot CCR (CCR_SAVE_EN only)
//   ccr        out  4    {V,C,N,Z}, registered
//   br_taken   out  1    registered one-cycle branch request
//   br_target  out  W    registered jump target, valid while br_taken=1
// ---------------------------------------------------------------------------
module ccr_branch_unit #(
    parameter int W   = 8,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ex_valid,
    input  logic           stall,
    input  logic           flush,
    input  logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   result,
    input  logic           int_save,
    output logic [3:0]     ccr,
    output logic           br_taken,
    output logic [W-1:0]   br_target
);

    localparam logic [OPW-1:0] OP_ADD  = 5'b00010;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00011;
    localparam logic [OPW-1:0] OP_AND  = 5'b00100;
    localparam logic [OPW-1:0] OP_OR   = 5'b00101;
    localparam logic [OPW-1:0] OP_RLC  = 5'b00110;
    localparam logic [OPW-1:0] OP_RRC  = 5'b00111;
    localparam logic [OPW-1:0] OP_SETC = 5'b01000;
    localparam logic [OPW-1:0] OP_CLRC = 5'b01001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b01110;
    localparam logic [OPW-1:0] OP_NEG  = 5'b01111;
    localparam logic [OPW-1:0] OP_INC  = 5'b10000;
    localparam logic [OPW-1:0] OP_DEC  = 5'b10001;
    localparam logic [OPW-1:0] OP_JZ   = 5'b10010;
    localparam logic [OPW-1:0] OP_JN   = 5'b10011;
    localparam logic [OPW-1:0] OP_JC   = 5'b10100;
    localparam logic [OPW-1:0] OP_JV   = 5'b10101;
    localparam logic [OPW-1:0] OP_LOOP = 5'b10110;
    localparam logic [OPW-1:0] OP_RTI  = 5'b11010;

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] ZERO     = {W{1'b0}};
    localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    // CCR bit positions inside {V,C,N,Z}
    localparam int V_BIT = 3;
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int Z_BIT = 0;

    logic [3:0]   ccr_r;
    logic         br_taken_r;
    logic [W-1:0] br_target_r;
    logic [3:0]   shadow_s;

    logic [3:0]   ccr_next_s;
    logic         taken_s;
    logic [W-1:0] target_next_s;
    logic [W:0]   sum_s;
    logic [W-1:0] loop_cnt_s;
    logic         z_res_s;
    logic         n_res_s;
    logic         exec_s;

    assign sum_s      = {1'b0, a} + {1'b0, b};
    assign loop_cnt_s = a - ONE;
    assign z_res_s    = (result == ZERO);
    assign n_res_s    = result[W-1];
    assign exec_s     = ex_valid && !flush;

`ifdef CCR_SAVE_EN
    logic [3:0] shadow_r;

    // Shadow CCR captured on interrupt entry whenever the pipe is not stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= 4'b0000;
        end else if (!stall && int_save) begin
            shadow_r <= ccr_r;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign shadow_s = shadow_r;
`else
    logic int_save_unused_s;

    assign int_save_unused_s = int_save;
    assign shadow_s          = 4'b0000;
`endif

    // Next-state flags and branch decision for an unstalled cycle
    always_comb begin
        ccr_next_s    = ccr_r;
        taken_s       = 1'b0;
        target_next_s = br_target_r;
        if (exec_s) begin
            case (alu_op)
                OP_ADD: begin
                    ccr_next_s[Z_BIT] = z_res_s;
                    ccr_next_s[N_BIT] = n_res_s;
                    ccr_next_s[C_BIT] = sum_s[W];
                    ccr_next_s[V_BIT] = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
                end
                OP_SUB: begin
                    ccr_next_s[Z_BIT] = z_res_s;
                    ccr_next_s[N_BIT] = n_res_s;
                    ccr_next_s[C_BIT] = (a < b);
                    ccr_next_s[V_BIT] = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
                end
                OP_AND, OP_OR, OP_NOT, OP_NEG: begin
                    ccr_next_s[Z_BIT] = z_res_s;
                    ccr_next_s[N_BIT] = n_res_s;
                end
                OP_INC: begin
                    ccr_next_s[Z_BIT] = z_res_s;
                    ccr_next_s[N_BIT] = n_res_s;
                    ccr_next_s[C_BIT] = (b == ALL_ONES);
                    ccr_next_s[V_BIT] = (b == MAX_POS);
                end
                OP_DEC: begin
                    ccr_next_s[Z_BIT] = z_res_s;
                    ccr_next_s[N_BIT] = n_res_s;
                    ccr_next_s[C_BIT] = (b == ZERO);
                    ccr_next_s[V_BIT] = (b == MIN_NEG);
                end
                OP_SETC: ccr_next_s[C_BIT] = 1'b1;
                OP_CLRC: ccr_next_s[C_BIT] = 1'b0;
                OP_RLC:  ccr_next_s[C_BIT] = b[W-1];
                OP_RRC:  ccr_next_s[C_BIT] = b[0];
                // A taken conditional jump consumes (clears) the flag it tested
                OP_JZ: begin
                    taken_s           = ccr_r[Z_BIT];
                    ccr_next_s[Z_BIT] = 1'b0;
                end
                OP_JN: begin
                    taken_s           = ccr_r[N_BIT];
                    ccr_next_s[N_BIT] = 1'b0;
                end
                OP_JC: begin
                    taken_s           = ccr_r[C_BIT];
                    ccr_next_s[C_BIT] = 1'b0;
                end
                OP_JV: begin
                    taken_s           = ccr_r[V_BIT];
                    ccr_next_s[V_BIT] = 1'b0;
                end
                // Counter wraps, so a==0 decrements to all-ones and still loops
                OP_LOOP: taken_s = (loop_cnt_s != ZERO);
`ifdef CCR_SAVE_EN
                OP_RTI:  ccr_next_s = shadow_s;
`else
                OP_RTI:  ccr_next_s = ccr_r;
`endif
                default: ccr_next_s = ccr_r;
            endcase
            if (taken_s) begin
                target_next_s = b;
            end else begin
                target_next_s = br_target_r;
            end
        end else begin
            ccr_next_s    = ccr_r;
            taken_s       = 1'b0;
            target_next_s = br_target_r;
        end
    end

    // Architectural CCR and registered branch request/target
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_r       <= 4'b0000;
            br_taken_r  <= 1'b0;
            br_target_r <= ZERO;
        end else if (stall) begin
            ccr_r       <= ccr_r;
            br_taken_r  <= 1'b0;
            br_target_r <= br_target_r;
        end else begin
            ccr_r       <= ccr_next_s;
            br_taken_r  <= taken_s;
            br_target_r <= target_next_s;
        end
    end

    assign ccr       = ccr_r;
    assign br_taken  = br_taken_r;
    assign br_target = br_target_r;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Directed bench for ccr_branch_unit: linear sequence of hand-computed vectors.
module tb_ccr_branch_unit;

    logic       clk;
    logic       rst;
    logic       ex_valid;
    logic       stall;
    logic       flush;
    logic [4:0] alu_op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       int_save;
    logic [3:0] ccr;
    logic       br_taken;
    logic [7:0] br_target;

    int errors = 0;
    int checks = 0;

    ccr_branch_unit #(.W(8), .OPW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .stall     (stall),
        .flush     (flush),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .result    (result),
        .int_save  (int_save),
        .ccr       (ccr),
        .br_taken  (br_taken),
        .br_target (br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one EX cycle, clock it, then sample 1 time unit after the edge
    task automatic step(input logic [4:0] op, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [7:0] res, input logic v, input logic st,
                        input logic fl, input logic is);
        alu_op   = op;
        a        = ta;
        b        = tb_;
        result   = res;
        ex_valid = v;
        stall    = st;
        flush    = fl;
        int_save = is;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] eccr,
                              input logic etk, input logic [7:0] etgt);
        check({tag, ".ccr"}, {28'd0, ccr}, {28'd0, eccr});
        check({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, etk});
        check({tag, ".br_target"}, {24'd0, br_target}, {24'd0, etgt});
    endtask

    initial begin
        rst = 1'b1;
        step(5'b00000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(5'b00000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("reset", 4'b0000, 1'b0, 8'h00);
        rst = 1'b0;

        // ADD 7F+01=80: signed overflow, no carry, negative
        step(5'b00010, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("add_ovf", 4'b1010, 1'b0, 8'h00);
        // SUB 05-05=0: Z only
        step(5'b00011, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("sub_zero", 4'b0001, 1'b0, 8'h00);
        // JZ taken, Z cleared
        step(5'b10010, 8'h00, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("jz_taken", 4'b0000, 1'b1, 8'h3C);
        // JZ back-to-back: now not taken, target held
        step(5'b10010, 8'h00, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("jz_again", 4'b0000, 1'b0, 8'h3C);
        // SETC
        step(5'b01000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("setc", 4'b0100, 1'b0, 8'h3C);
        // JC stalled: nothing happens
        step(5'b10100, 8'h00, 8'h22, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("jc_stall", 4'b0100, 1'b0, 8'h3C);
        // JC released: taken, C cleared
        step(5'b10100, 8'h00, 8'h22, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("jc_taken", 4'b0000, 1'b1, 8'h22);
        // LOOP a=1 -> not taken
        step(5'b10110, 8'h01, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("loop_a1", 4'b0000, 1'b0, 8'h22);
        // LOOP a=3 -> taken
        step(5'b10110, 8'h03, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("loop_a3", 4'b0000, 1'b1, 8'h10);
        // LOOP flushed -> none
        step(5'b10110, 8'h03, 8'h44, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("loop_flush", 4'b0000, 1'b0, 8'h10);
        // LOOP a=0 wraps -> taken
        step(5'b10110, 8'h00, 8'h66, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("loop_a0", 4'b0000, 1'b1, 8'h66);
        // ADD with ex_valid=0: ignored
        step(5'b00010, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("add_invalid", 4'b0000, 1'b0, 8'h66);
        // ADD FF+01=00: carry and zero
        step(5'b00010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("add_carry", 4'b0101, 1'b0, 8'h66);
        // SUB 80-01=7F: overflow, no borrow
        step(5'b00011, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("sub_ovf", 4'b1000, 1'b0, 8'h66);
        // JV taken, V cleared
        step(5'b10101, 8'h00, 8'h99, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("jv_taken", 4'b0000, 1'b1, 8'h99);
        // INC 7F -> 80: V, N
        step(5'b10000, 8'h00, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("inc_ovf", 4'b1010, 1'b0, 8'h99);
        // Interrupt snapshot with no valid instruction
        step(5'b00000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("int_save", 4'b1010, 1'b0, 8'h99);
        step(5'b01000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("setc2", 4'b1110, 1'b0, 8'h99);
        step(5'b11010, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef CCR_SAVE_EN
        expect_out("rti_restore", 4'b1010, 1'b0, 8'h99);
`else
        expect_out("rti_hold", 4'b1110, 1'b0, 8'h99);
`endif
        // DEC 00 -> FF: borrow, negative
        step(5'b10001, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("dec_zero", 4'b0110, 1'b0, 8'h99);
        // JN taken, N cleared
        step(5'b10011, 8'h00, 8'h12, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("jn_taken", 4'b0100, 1'b1, 8'h12);
        // RRC b=02 -> C=0
        step(5'b00111, 8'h00, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("rrc", 4'b0000, 1'b0, 8'h12);
        // RLC b=80 -> C=1
        step(5'b00110, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("rlc", 4'b0100, 1'b0, 8'h12);
        // AND result 0 -> Z set, C held
        step(5'b00100, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("and_zero", 4'b0101, 1'b0, 8'h12);
        // JZ taken so br_taken is high
        step(5'b10010, 8'h00, 8'hAB, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("jz_pre_rst", 4'b0100, 1'b1, 8'hAB);
        // Reset together with stall while br_taken is high
        rst = 1'b1;
        step(5'b00010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("rst_mid", 4'b0000, 1'b0, 8'h00);
        rst = 1'b0;
        step(5'b00000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
